// File: rtl/dca_lsu_txn_scheduler.sv
// dca_lsu_txn_scheduler
// Walks a strided tile (base, rows, row bytes, stride) and emits one
// AXI-legal burst descriptor per cycle, splitting each row at the maximum
// burst length and at 4 KB boundaries.
module dca_lsu_txn_scheduler #(
  parameter int BW_ADDR       = 32,
  parameter int BW_AXI_DATA   = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int BW_NUM_ROW    = 16,
  parameter int BW_ROW_BYTES  = 16,
  parameter int BW_AXI_ALEN   = 8,
  parameter int BW_BITADDR    = BW_ADDR + 3,
  parameter int BW_TXN_INFO   = 2 + BW_AXI_ALEN + BW_BITADDR
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_clear,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic [BW_ADDR-1:0]      i_cmd_base_addr,
  input  logic [BW_ADDR-1:0]      i_cmd_row_stride,
  input  logic [BW_NUM_ROW-1:0]   i_cmd_num_row,
  input  logic [BW_ROW_BYTES-1:0] i_cmd_row_bytes,
  output logic                    o_txn_valid,
  input  logic                    i_txn_ready,
  output logic [BW_TXN_INFO-1:0]  o_txn_info,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error
);

  localparam int BYTES_PER_BEAT = BW_AXI_DATA / 8;
  localparam int LOG2_BPB       = $clog2(BYTES_PER_BEAT);
  // Wide enough for a full row in beats, 4096 beats of 4 KB room and 256-beat bursts.
  localparam int BW_CNT         = ((BW_ROW_BYTES > 14) ? BW_ROW_BYTES : 14) + 1;

  localparam logic [BW_CNT-1:0]       MAX_BEATS = BW_CNT'(MAX_BURST_LEN);
  localparam logic [BW_ADDR-1:0]      ADDR_MASK = BW_ADDR'(BYTES_PER_BEAT - 1);
  localparam logic [BW_ROW_BYTES-1:0] LEN_MASK  = BW_ROW_BYTES'(BYTES_PER_BEAT - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                  r_state;
  logic [BW_ADDR-1:0]      r_row_addr;
  logic [BW_ADDR-1:0]      r_cur_addr;
  logic [BW_ADDR-1:0]      r_stride;
  logic [BW_NUM_ROW-1:0]   r_rows_left;
  logic [BW_ROW_BYTES-1:0] r_row_beats;
  logic [BW_ROW_BYTES-1:0] r_row_beats_left;
  logic                    r_done;
  logic                    r_error;

  logic [12:0]             w_4k_bytes;
  logic [BW_CNT-1:0]       w_4k_beats;
  logic [BW_CNT-1:0]       w_row_beats;
  logic [BW_CNT-1:0]       w_beats;
  logic [BW_AXI_ALEN-1:0]  w_alen;
  logic                    w_is_row_end;
  logic                    w_is_last;
  logic [BW_ADDR-1:0]      w_step;
  logic [BW_ADDR-1:0]      w_next_row;
  logic                    w_accept;
  logic                    w_misaligned;
  logic                    w_empty;
  logic [BW_ROW_BYTES-1:0] w_cmd_beats;

  assign o_cmd_ready = (r_state == IDLE) && i_enable && !i_rst && !i_clear;
  assign o_txn_valid = (r_state == ISSUE) && i_enable;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_error     = r_error;

  assign w_accept     = o_cmd_ready && i_cmd_valid;
  assign w_misaligned = ((i_cmd_base_addr & ADDR_MASK) != '0) ||
                        ((i_cmd_row_stride & ADDR_MASK) != '0) ||
                        ((i_cmd_row_bytes & LEN_MASK) != '0);
  assign w_empty      = (i_cmd_num_row == '0) || (i_cmd_row_bytes == '0);
  assign w_cmd_beats  = i_cmd_row_bytes >> LOG2_BPB;

  // Room left before the next 4 KB boundary, in beats (1..4096/BYTES_PER_BEAT).
  assign w_4k_bytes  = 13'h1000 - {1'b0, r_cur_addr[11:0]};
  assign w_4k_beats  = BW_CNT'(w_4k_bytes >> LOG2_BPB);
  assign w_row_beats = BW_CNT'(r_row_beats_left);

  // Burst size: smallest of remaining row, max burst and 4 KB room.
  always_comb begin
    w_beats = w_row_beats;
    if (MAX_BEATS < w_beats) begin
      w_beats = MAX_BEATS;
    end
    if (w_4k_beats < w_beats) begin
      w_beats = w_4k_beats;
    end
  end

  assign w_alen       = BW_AXI_ALEN'(w_beats - BW_CNT'(1));
  assign w_is_row_end = (w_beats == w_row_beats);
  assign w_is_last    = w_is_row_end && (r_rows_left == BW_NUM_ROW'(1));
  assign w_step       = BW_ADDR'(w_beats) << LOG2_BPB;
  assign w_next_row   = r_row_addr + r_stride;

  // Descriptor is built purely from registered cursor state; zero when idle.
  assign o_txn_info = (r_state == ISSUE) ?
                      {w_is_last, w_is_row_end, w_alen, r_cur_addr, 3'b000} : '0;

  // Command accept, row/burst cursor advance and done/error pulse generation.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_state          <= IDLE;
      r_row_addr       <= '0;
      r_cur_addr       <= '0;
      r_stride         <= '0;
      r_rows_left      <= '0;
      r_row_beats      <= '0;
      r_row_beats_left <= '0;
      r_done           <= 1'b0;
      r_error          <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      if (i_enable) begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              if (w_misaligned) begin
                r_error <= 1'b1;
              end else if (w_empty) begin
                r_done <= 1'b1;
              end else begin
                r_row_addr       <= i_cmd_base_addr;
                r_cur_addr       <= i_cmd_base_addr;
                r_stride         <= i_cmd_row_stride;
                r_rows_left      <= i_cmd_num_row;
                r_row_beats      <= w_cmd_beats;
                r_row_beats_left <= w_cmd_beats;
                r_state          <= ISSUE;
              end
            end
          end
          ISSUE: begin
            if (i_txn_ready) begin
              if (w_is_last) begin
                r_state          <= IDLE;
                r_done           <= 1'b1;
                r_rows_left      <= '0;
                r_row_beats_left <= '0;
              end else if (w_is_row_end) begin
                r_row_addr       <= w_next_row;
                r_cur_addr       <= w_next_row;
                r_row_beats_left <= r_row_beats;
                r_rows_left      <= r_rows_left - BW_NUM_ROW'(1);
              end else begin
                r_cur_addr       <= r_cur_addr + w_step;
                r_row_beats_left <= r_row_beats_left - BW_ROW_BYTES'(w_beats);
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
